multi_channel_pulse_width_detector: RTL and testbench
=====================================================

// Module: multi_channel_pulse_width_detector
//
// PURPOSE
//   Parametrised, multi-channel successor to the single-channel 010 pulse detector.
//   Per channel: flags rising/falling edges, measures every high run, and reports
//   runs of MIN_W..MAX_W cycles as valid pulses and runs longer than MAX_W as too-long.
//   A shared saturating counter totals the valid pulses.
//   Sits behind raw control/status inputs as a qualifier for event and interrupt logic.
//
// PARAMETERS
//   CH     4   number of independent input channels (>=1)
//   MIN_W  1   shortest high run accepted as a pulse, in cycles (>=1)
//   MAX_W  1   longest high run accepted as a pulse (>=MIN_W); MIN_W=MAX_W=1 gives a 010 detector
//   CNT_W  16  width of the total pulse counter
//   LEN_W  localparam = $clog2(MAX_W+2); width of each run-length field
//
// PORTS
//   clk        input   1          clock, all state on posedge
//   rst        input   1          asynchronous, active-low reset
//   a          input   CH         channel inputs, sampled on posedge clk
//   cnt_clr    input   1          synchronous clear of pulse_cnt
//   rise       output  CH         one-cycle strobe: armed channel went 0->1
//   fall       output  CH         one-cycle strobe: channel went 1->0
//   pulse_det  output  CH         one-cycle strobe: valid pulse ended
//   too_long   output  CH         one-cycle strobe: high run longer than MAX_W ended
//   pulse_len  output  CH*LEN_W   length of the last completed high run; channel i in [i*LEN_W +: LEN_W]
//   pulse_cnt  output  CNT_W      total valid pulses since reset/clear, saturating
//
// BEHAVIOUR
//   - Reset (rst=0, async):
//       - every channel goes to ARM; run counters are cleared;
//       - all outputs are 0, including pulse_len and pulse_cnt;
//       - a run in progress is discarded and never reported.
//   - Per-channel FSM, evaluated on input s = a[i] at each posedge:
//       - ARM: s=0 -> LOW; s=1 -> stay in ARM. A line held high out of reset is never counted.
//       - LOW: s=1 -> HIGH, run=1, rise strobe; s=0 -> stay in LOW.
//       - HIGH, s=1: run <= run+1, saturating at MAX_W+1; stay in HIGH.
//       - HIGH, s=0: fall strobe; go to LOW; pulse_len[i] <= run; then classify the run:
//           - MIN_W<=run<=MAX_W -> pulse_det strobe;
//           - run==MAX_W+1 (saturated) -> too_long strobe;
//           - run<MIN_W -> no strobe; this is a glitch and is rejected silently.
//   - All strobes are registered and high for exactly one cycle after the edge that
//     captured the deciding sample (latency 1).
//       - With MIN_W=MAX_W=1, pulse_det matches the 010 detector's timing.
//   - pulse_len holds its value between run completions.
//   - pulse_det and too_long are mutually exclusive. fall is 1 whenever either is 1.
//   - Channels are fully independent; any number may strobe in the same cycle.
//   - pulse_cnt update each cycle:
//       - pulse_cnt <= min(pulse_cnt + popcount(pulse_det_next), 2^CNT_W-1);
//       - cnt_clr=1 forces 0 and has priority over that cycle's detections, which are not counted.
//   - Back-to-back pulses need at least one low cycle between them (HIGH->LOW->HIGH).
//   - Parameter violations (MIN_W<1, MAX_W<MIN_W, CH<1) are caught by an elaboration-time $error.
//
// CONFIGURATION
//   PULSE_DET_SYNC_EN
//     - Defined: each a[i] passes through a 2-flop synchronizer before the FSM.
//       The synchronizer flops are reset to 0. All strobes arrive 2 cycles later (latency 3).
//       a may be asynchronous to clk.
//     - Undefined: a is sampled directly and must be synchronous to clk (latency 1).
//
// TESTING  (macro undefined; CH=4, MIN_W=2, MAX_W=4, CNT_W=4 unless noted)
//   1. a[0] = 0,1,1,0 (after a low) -> rise[0] the cycle after the first 1;
//      fall[0] and pulse_det[0] the cycle after the 0; pulse_len[0]=2; pulse_cnt=1.
//   2. a[1] = 0,1,0 -> rise[1] and fall[1] only; pulse_det[1]=0; pulse_len[1]=1 (glitch rejected).
//   3. a[2] = 0, then 7 highs, then 0 -> too_long[2]=1, pulse_det[2]=0, pulse_len[2]=5.
//   4. a[3] high from reset release for 3 cycles, then 0,1,1,0 -> first run ignored (ARM);
//      the second run gives exactly one pulse_det[3].
//   5. Valid pulses ending on all 4 channels in the same cycle -> pulse_cnt += 4.
//      Repeat to reach 15 -> saturates at 15. Then cnt_clr coinciding with a detection -> pulse_cnt=0.
//   6. Drop rst mid-run (a[0] high for 3 cycles), release, then drive 0 -> no strobes and all outputs 0.
//      Repeat test 1 with PULSE_DET_SYNC_EN defined -> identical strobes delayed by 2 cycles.

Source files
------------

// File: rtl/multi_channel_pulse_width_detector_if.sv
// Bundles channel inputs, counter clear and all strobe/length/count results of the detector.
// The master drives the channel lines and the clear; the slave is the detector.
interface multi_channel_pulse_width_detector_if #(
    parameter int CH    = 4,
    parameter int MAX_W = 1,
    parameter int CNT_W = 16
);
    localparam int LEN_W = $clog2(MAX_W + 2);

    logic [CH-1:0]       a;
    logic                cnt_clr;
    logic [CH-1:0]       rise;
    logic [CH-1:0]       fall;
    logic [CH-1:0]       pulse_det;
    logic [CH-1:0]       too_long;
    logic [CH*LEN_W-1:0] pulse_len;
    logic [CNT_W-1:0]    pulse_cnt;

    modport master (
        output a, cnt_clr,
        input  rise, fall, pulse_det, too_long, pulse_len, pulse_cnt
    );

    modport slave (
        input  a, cnt_clr,
        output rise, fall, pulse_det, too_long, pulse_len, pulse_cnt
    );
endinterface

// File: rtl/multi_channel_pulse_width_detector.sv
// Per-channel edge flags, high-run length measurement and MIN_W..MAX_W pulse qualification.
// Latency 1 cycle (3 with PULSE_DET_SYNC_EN defined: 2-flop input synchronizer added).
// No backpressure: strobes are single-cycle and must be consumed when asserted.
module multi_channel_pulse_width_detector #(
    parameter int CH    = 4,
    parameter int MIN_W = 1,
    parameter int MAX_W = 1,
    parameter int CNT_W = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    multi_channel_pulse_width_detector_if.slave  bus
);
    localparam int LEN_W = $clog2(MAX_W + 2);
    localparam int POP_W = $clog2(CH + 1);
    localparam int SUM_W = CNT_W + POP_W;

    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_W);
    localparam logic [LEN_W-1:0] SAT_L   = LEN_W'(MAX_W + 1);
    localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_ARM  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_e;

    if (CH < 1 || MIN_W < 1 || MAX_W < MIN_W) begin : g_param_check
        $error("multi_channel_pulse_width_detector: illegal parameters (need CH>=1, MIN_W>=1, MAX_W>=MIN_W)");
    end

    logic [CH-1:0] s_vec;

`ifdef PULSE_DET_SYNC_EN
    logic [CH-1:0] sync1_q;
    logic [CH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.a;
            sync2_q <= sync1_q;
        end
    end

    assign s_vec = sync2_q;
`else
    assign s_vec = bus.a;
`endif

    state_e              state_q [CH];
    state_e              state_d [CH];
    logic [LEN_W-1:0]    run_q   [CH];
    logic [LEN_W-1:0]    run_d   [CH];
    logic [CH-1:0]       rise_q, rise_d;
    logic [CH-1:0]       fall_q, fall_d;
    logic [CH-1:0]       det_q,  det_d;
    logic [CH-1:0]       long_q, long_d;
    logic [CH*LEN_W-1:0] len_q,  len_d;
    logic [CNT_W-1:0]    cnt_q,  cnt_d;
    logic [POP_W-1:0]    pop;
    logic [SUM_W-1:0]    sum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= ST_ARM;
                run_q[i]   <= '0;
            end
            rise_q <= '0;
            fall_q <= '0;
            det_q  <= '0;
            long_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                state_q[i] <= state_d[i];
                run_q[i]   <= run_d[i];
            end
            rise_q <= rise_d;
            fall_q <= fall_d;
            det_q  <= det_d;
            long_q <= long_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        rise_d = '0;
        fall_d = '0;
        det_d  = '0;
        long_d = '0;
        len_d  = len_q;
        pop    = '0;
        for (int i = 0; i < CH; i++) begin
            state_d[i] = state_q[i];
            run_d[i]   = run_q[i];
            case (state_q[i])
                // A line high out of reset must first be seen low before a run can start.
                ST_ARM: begin
                    if (!s_vec[i]) state_d[i] = ST_LOW;
                end
                ST_LOW: begin
                    if (s_vec[i]) begin
                        state_d[i] = ST_HIGH;
                        run_d[i]   = ONE_L;
                        rise_d[i]  = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (s_vec[i]) begin
                        if (run_q[i] != SAT_L) run_d[i] = run_q[i] + ONE_L;
                    end else begin
                        state_d[i] = ST_LOW;
                        fall_d[i]  = 1'b1;
                        len_d[i*LEN_W +: LEN_W] = run_q[i];
                        if (run_q[i] == SAT_L)      long_d[i] = 1'b1;
                        else if (run_q[i] >= MIN_L) det_d[i]  = 1'b1;
                    end
                end
                default: state_d[i] = ST_ARM;
            endcase
            pop = pop + POP_W'(det_d[i]);
        end

        // Widened sum so the saturation test cannot itself wrap.
        sum = SUM_W'(cnt_q) + SUM_W'(pop);
        if (bus.cnt_clr)                  cnt_d = '0;
        else if (sum > SUM_W'(CNT_MAX))   cnt_d = CNT_MAX;
        else                              cnt_d = sum[CNT_W-1:0];
    end

    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.pulse_det = det_q;
    assign bus.too_long  = long_q;
    assign bus.pulse_len = len_q;
    assign bus.pulse_cnt = cnt_q;
endmodule

// File: tb/tb_multi_channel_pulse_width_detector.sv
// Bench for the multi-channel pulse width detector: directed vector table, hand-written
// reset/arming sequences and randomized runs compared against a behavioural model.
module tb_multi_channel_pulse_width_detector;
    localparam int CH    = 4;
    localparam int MIN_W = 2;
    localparam int MAX_W = 4;
    localparam int CNT_W = 4;
    localparam int LEN_W = $clog2(MAX_W + 2);
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    multi_channel_pulse_width_detector_if #(.CH(CH), .MAX_W(MAX_W), .CNT_W(CNT_W)) bus ();

    multi_channel_pulse_width_detector #(
        .CH(CH), .MIN_W(MIN_W), .MAX_W(MAX_W), .CNT_W(CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit                  armed  [CH];
    bit                  in_run [CH];
    int                  run    [CH];
    int                  lenv_m [CH];
    int                  cnt_m;
    logic [CH-1:0]       d1, d2;
    logic [CH-1:0]       m_rise, m_fall, m_det, m_tl;
    logic [CH*LEN_W-1:0] m_len;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            armed[i] = 0; in_run[i] = 0; run[i] = 0; lenv_m[i] = 0;
        end
        cnt_m = 0; d1 = '0; d2 = '0;
        m_rise = '0; m_fall = '0; m_det = '0; m_tl = '0; m_len = '0;
    endtask

    task automatic model_step(input logic [CH-1:0] av, input logic clr);
        logic [CH-1:0] eff;
        int pc;
`ifdef PULSE_DET_SYNC_EN
        eff = d2; d2 = d1; d1 = av;
`else
        eff = av;
`endif
        m_rise = '0; m_fall = '0; m_det = '0; m_tl = '0; pc = 0;
        for (int i = 0; i < CH; i++) begin
            if (!armed[i]) begin
                if (!eff[i]) armed[i] = 1;
            end else if (eff[i]) begin
                if (!in_run[i]) begin
                    m_rise[i] = 1'b1; in_run[i] = 1; run[i] = 1;
                end else begin
                    run[i]++;
                end
            end else if (in_run[i]) begin
                in_run[i] = 0;
                m_fall[i] = 1'b1;
                lenv_m[i] = (run[i] > MAX_W) ? MAX_W + 1 : run[i];
                if (run[i] >= MIN_W && run[i] <= MAX_W) begin
                    m_det[i] = 1'b1; pc++;
                end else if (run[i] > MAX_W) begin
                    m_tl[i] = 1'b1;
                end
            end
            m_len[i*LEN_W +: LEN_W] = LEN_W'(lenv_m[i]);
        end
        if (clr) cnt_m = 0;
        else     cnt_m = (cnt_m + pc > CMAX) ? CMAX : cnt_m + pc;
    endtask

    task automatic step(input logic [CH-1:0] av, input logic clr);
        bus.a = av;
        bus.cnt_clr = clr;
        @(posedge clk);
        #1;
        model_step(av, clr);
        chk("model_rise",      bus.rise,      m_rise);
        chk("model_fall",      bus.fall,      m_fall);
        chk("model_pulse_det", bus.pulse_det, m_det);
        chk("model_too_long",  bus.too_long,  m_tl);
        chk("model_pulse_len", bus.pulse_len, m_len);
        chk("model_pulse_cnt", bus.pulse_cnt, cnt_m);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rise"},      bus.rise,      0);
        chk({tag, "_fall"},      bus.fall,      0);
        chk({tag, "_pulse_det"}, bus.pulse_det, 0);
        chk({tag, "_too_long"},  bus.too_long,  0);
        chk({tag, "_pulse_len"}, bus.pulse_len, 0);
        chk({tag, "_pulse_cnt"}, bus.pulse_cnt, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [CH-1:0]       a;
        logic                clr;
        logic [CH-1:0]       rise, fall, det, tl;
        logic [CH*LEN_W-1:0] len;
        logic [CNT_W-1:0]    cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [CH*LEN_W-1:0] lv(input int l3, input int l2, input int l1, input int l0);
        return {LEN_W'(l3), LEN_W'(l2), LEN_W'(l1), LEN_W'(l0)};
    endfunction

    function automatic void add(input logic [CH-1:0] a, input logic clr, input logic [CH-1:0] r,
                                input logic [CH-1:0] f, input logic [CH-1:0] d, input logic [CH-1:0] t,
                                input logic [CH*LEN_W-1:0] l, input int c);
        vec_t v;
        v.a = a; v.clr = clr; v.rise = r; v.fall = f; v.det = d; v.tl = t;
        v.len = l; v.cnt = CNT_W'(c);
        tbl.push_back(v);
    endfunction

    int            n_det3, n_rise3, n_tl3;
    int            hold [CH];
    logic [CH-1:0] cur;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CH*LEN_W-1:0] pl;
        int pc;

        // test 1: 2-cycle pulse on ch0
        add(4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, lv(0,0,0,0), 0);
        add(4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, lv(0,0,0,0), 0);
        add(4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, lv(0,0,0,0), 0);
        add(4'b0000, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, lv(0,0,0,2), 1);
        // test 2: 1-cycle glitch on ch1
        add(4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, lv(0,0,0,2), 1);
        add(4'b0000, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, lv(0,0,1,2), 1);
        // test 3: 7-cycle run on ch2
        add(4'b0100, 0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, lv(0,0,1,2), 1);
        for (int k = 0; k < 6; k++)
            add(4'b0100, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, lv(0,0,1,2), 1);
        add(4'b0000, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0100, lv(0,5,1,2), 1);
        // test 5: simultaneous pulses on all channels up to saturation
        pl = lv(0,5,1,2);
        pc = 1;
        for (int k = 0; k < 4; k++) begin
            add(4'b1111, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, pl, pc);
            add(4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, pl, pc);
            pc = (pc + 4 > CMAX) ? CMAX : pc + 4;
            pl = lv(2,2,2,2);
            add(4'b0000, 0, 4'b0000, 4'b1111, 4'b1111, 4'b0000, pl, pc);
        end
        add(4'b1111, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, pl, 15);
        add(4'b1111, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, pl, 15);
        add(4'b0000, 1, 4'b0000, 4'b1111, 4'b1111, 4'b0000, pl, 0);
        // exactly MAX_W on ch3 is a valid pulse
        add(4'b1000, 0, 4'b1000, 4'b0000, 4'b0000, 4'b0000, pl, 0);
        for (int k = 0; k < 3; k++)
            add(4'b1000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, pl, 0);
        add(4'b0000, 0, 4'b0000, 4'b1000, 4'b1000, 4'b0000, lv(4,2,2,2), 1);
        // exactly MAX_W+1 on ch1 is too long
        add(4'b0010, 0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, lv(4,2,2,2), 1);
        for (int k = 0; k < 4; k++)
            add(4'b0010, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, lv(4,2,2,2), 1);
        add(4'b0000, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0010, lv(4,2,5,2), 1);
        // back-to-back pulses on ch0 with a single low cycle between
        add(4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, lv(4,2,5,2), 1);
        add(4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, lv(4,2,5,2), 1);
        add(4'b0000, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, lv(4,2,5,2), 2);
        add(4'b0001, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, lv(4,2,5,2), 2);
        add(4'b0001, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, lv(4,2,5,2), 2);
        add(4'b0000, 0, 4'b0000, 4'b0001, 4'b0001, 4'b0000, lv(4,2,5,2), 3);

        // reset state
        rst = 1'b0;
        bus.a = '0;
        bus.cnt_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[k]) begin
            step(tbl[k].a, tbl[k].clr);
`ifndef PULSE_DET_SYNC_EN
            chk($sformatf("tbl%0d_rise", k),      bus.rise,      tbl[k].rise);
            chk($sformatf("tbl%0d_fall", k),      bus.fall,      tbl[k].fall);
            chk($sformatf("tbl%0d_pulse_det", k), bus.pulse_det, tbl[k].det);
            chk($sformatf("tbl%0d_too_long", k),  bus.too_long,  tbl[k].tl);
            chk($sformatf("tbl%0d_pulse_len", k), bus.pulse_len, tbl[k].len);
            chk($sformatf("tbl%0d_pulse_cnt", k), bus.pulse_cnt, tbl[k].cnt);
`endif
        end

        // test 4: ch3 high out of reset must be ignored until it is seen low
        @(negedge clk);
        rst = 1'b0;
        bus.a = 4'b1000;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        n_det3 = 0; n_rise3 = 0; n_tl3 = 0;
        foreach (cur[j]) cur[j] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0, 1, 2, 4, 5: cur = 4'b1000;
                default:       cur = 4'b0000;
            endcase
            step(cur, 1'b0);
            n_det3  += int'(bus.pulse_det[3]);
            n_rise3 += int'(bus.rise[3]);
            n_tl3   += int'(bus.too_long[3]);
        end
`ifndef PULSE_DET_SYNC_EN
        chk("arm_det3_count",  n_det3,  1);
        chk("arm_rise3_count", n_rise3, 1);
        chk("arm_tl3_count",   n_tl3,   0);
        chk("arm_len3",        bus.pulse_len[3*LEN_W +: LEN_W], 2);
`endif

        // test 6: reset dropped mid-run discards the run
        step(4'b0000, 1'b0);
        repeat (3) step(4'b0001, 1'b0);
        rst = 1'b0;
        #2;
        chk_all_zero("midrun_reset");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(4'b0000, 1'b0);
            chk_all_zero($sformatf("post_reset%0d", k));
        end

        // randomized runs against the model
        cur = '0;
        for (int i = 0; i < CH; i++) hold[i] = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < CH; i++) begin
                if (hold[i] == 0) begin
                    cur[i]  = ~cur[i];
                    hold[i] = cur[i] ? int'($urandom_range(1, 7)) : int'($urandom_range(1, 3));
                end
                hold[i]--;
            end
            step(cur, $urandom_range(0, 39) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
